// File: rtl/cache_dma_pkg.sv
// -----------------------------------------------------------------------------
// cache_dma_pkg
// Shared types for the cache DMA engine:
//   state_t  - engine FSM states
//   kind_t   - transaction kind latched at arbitration (line writeback or refill)
//   ptr_bits - width helper that never returns 0 for a 1-entry index
// -----------------------------------------------------------------------------
package cache_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_t;

    typedef enum logic {
        KIND_EVICT,
        KIND_FILL
    } kind_t;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_dma_rr_arb.sv
// -----------------------------------------------------------------------------
// cache_dma_rr_arb
// Round-robin priority picker: the first requester at or after ptr (wrapping)
// wins.
// Ports:
//   req   in  NUM_CH    request vector
//   ptr   in  PTR_BITS  index of the highest-priority requester this cycle
//   gnt   out NUM_CH    one-hot grant (all zero when nothing requests)
//   valid out 1         some requester was granted
// -----------------------------------------------------------------------------
module cache_dma_rr_arb
    import cache_dma_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PTR_BITS = ptr_bits(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [NUM_CH-1:0]   gnt,
    output logic                valid
);

    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_dma_engine.sv
// -----------------------------------------------------------------------------
// cache_dma_engine
// Multi-channel line DMA between L1 caches and a word-wide memory port. Each
// channel may request a line refill (req_i) and a line writeback (evict_i);
// channels are served round-robin, and within a channel the writeback goes
// first so a dirty line reaches memory before its replacement is fetched.
// Lines are moved as BLOCK_BITS/WORD_BITS beats on a grant/rvalid bus.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i, req_addr_i     per-channel refill request (level) and byte address
//   evict_i, evict_addr_i per-channel writeback request (level), line address
//   evict_data_i          per-channel writeback line
//   fill_valid_o          one-cycle pulse per channel: refilled line ready
//   fill_data_o           refilled line (held until the next refill)
//   fill_addr_o           line-aligned address of the refilled line
//   evict_done_o          one-cycle pulse per channel: writeback complete
//   mem_req_o, mem_we_o   beat request, write enable
//   mem_addr_o            beat byte address
//   mem_wdata_o           write beat data
//   mem_gnt_i             memory accepts the current beat
//   mem_rvalid_i          read data valid (only honoured while waiting)
//   mem_rdata_i           read data
//
// Build option CACHE_DMA_CRITICAL_WORD_FIRST_EN: refills start at the beat
// holding req_addr_i and wrap within the line; each word still lands at its
// true position in fill_data_o. Without it refills start at beat 0.
// -----------------------------------------------------------------------------
module cache_dma_engine
    import cache_dma_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int BLOCK_BITS = 512,
    parameter int WORD_BITS  = 32,
    parameter int ADDR_BITS  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH*ADDR_BITS-1:0]  req_addr_i,
    input  logic [NUM_CH-1:0]            evict_i,
    input  logic [NUM_CH*ADDR_BITS-1:0]  evict_addr_i,
    input  logic [NUM_CH*BLOCK_BITS-1:0] evict_data_i,
    output logic [NUM_CH-1:0]            fill_valid_o,
    output logic [BLOCK_BITS-1:0]        fill_data_o,
    output logic [ADDR_BITS-1:0]         fill_addr_o,
    output logic [NUM_CH-1:0]            evict_done_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDR_BITS-1:0]         mem_addr_o,
    output logic [WORD_BITS-1:0]         mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [WORD_BITS-1:0]         mem_rdata_i
);

    localparam int BEATS      = BLOCK_BITS / WORD_BITS;
    localparam int BEAT_BYTES = WORD_BITS / 8;
    localparam int LINE_BYTES = BLOCK_BITS / 8;
    localparam int BEAT_BITS  = ptr_bits(BEATS);
    localparam int CH_BITS    = ptr_bits(NUM_CH);

    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~(ADDR_BITS'(LINE_BYTES) - 1'b1);
    localparam logic [BEAT_BITS-1:0] LAST_IDX  = BEAT_BITS'(BEATS - 1);

    state_t                state, state_next;
    kind_t                 kind;
    logic [CH_BITS-1:0]    ch, rr_ptr, sel;
    logic [ADDR_BITS-1:0]  base, beat_off, sel_req_addr, sel_evict_addr;
    logic [BEAT_BITS-1:0]  beat, last_beat, beat_inc, fill_start, fill_last;
    logic [BLOCK_BITS-1:0] line;
    logic [NUM_CH-1:0]     any_req, gnt, ch_onehot;
    logic                  arb_valid, beat_last;

    assign any_req = req_i | evict_i;

    cache_dma_rr_arb #(
        .NUM_CH   (NUM_CH),
        .PTR_BITS (CH_BITS)
    ) u_arb (
        .req   (any_req),
        .ptr   (rr_ptr),
        .gnt   (gnt),
        .valid (arb_valid)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel = CH_BITS'(i);
            end
        end
    end

    assign sel_req_addr   = req_addr_i[int'(sel)*ADDR_BITS +: ADDR_BITS];
    assign sel_evict_addr = evict_addr_i[int'(sel)*ADDR_BITS +: ADDR_BITS];

`ifdef CACHE_DMA_CRITICAL_WORD_FIRST_EN
    // Word index of the requested address inside its line; the transfer ends
    // on the word just before it, wrapping through the line base.
    assign fill_start = BEAT_BITS'((sel_req_addr & ~LINE_MASK) / ADDR_BITS'(BEAT_BYTES));
    assign fill_last  = (fill_start == '0) ? LAST_IDX : fill_start - 1'b1;
`else
    assign fill_start = '0;
    assign fill_last  = LAST_IDX;
`endif

    // Explicit wrap keeps the counter correct even when BEATS is not a power of two.
    assign beat_inc  = (beat == LAST_IDX) ? '0 : beat + 1'b1;
    assign beat_last = (beat == last_beat);
    assign beat_off  = ADDR_BITS'(beat) * ADDR_BITS'(BEAT_BYTES);
    assign ch_onehot = NUM_CH'(1) << ch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        fill_valid_o = '0;
        evict_done_o = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = evict_i[sel] ? WR_BEAT : RD_REQ;
                end
            end
            WR_BEAT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = base + beat_off;
                mem_wdata_o = line[int'(beat)*WORD_BITS +: WORD_BITS];
                if (mem_gnt_i && beat_last) begin
                    state_next = DONE;
                end
            end
            RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base + beat_off;
                if (mem_gnt_i) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    state_next = beat_last ? DONE : RD_REQ;
                end
            end
            DONE: begin
                if (kind == KIND_EVICT) begin
                    evict_done_o = ch_onehot;
                end else begin
                    fill_valid_o = ch_onehot;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kind        <= KIND_FILL;
            ch          <= '0;
            rr_ptr      <= '0;
            base        <= '0;
            beat        <= '0;
            last_beat   <= '0;
            fill_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        ch <= sel;
                        if (evict_i[sel]) begin
                            kind      <= KIND_EVICT;
                            base      <= sel_evict_addr & LINE_MASK;
                            beat      <= '0;
                            last_beat <= LAST_IDX;
                        end else begin
                            kind      <= KIND_FILL;
                            base      <= sel_req_addr & LINE_MASK;
                            beat      <= fill_start;
                            last_beat <= fill_last;
                        end
                    end
                end
                WR_BEAT: begin
                    if (mem_gnt_i) begin
                        beat <= beat_inc;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        fill_data_o[int'(beat)*WORD_BITS +: WORD_BITS] <= mem_rdata_i;
                        beat <= beat_inc;
                    end
                end
                DONE: begin
                    rr_ptr <= (ch == CH_BITS'(NUM_CH - 1)) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the writeback line buffer has no reset; it is always loaded before
    // it is read, so clearing it would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && arb_valid && evict_i[sel]) begin
            line <= evict_data_i[int'(sel)*BLOCK_BITS +: BLOCK_BITS];
        end
    end

    assign fill_addr_o = base;

endmodule

// File: tb/tb_cache_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_cache_dma_engine
// Scoreboard bench for cache_dma_engine (default parameters). Expected memory
// beats, done pulses and refilled lines are queued when stimulus is driven and
// compared as the engine produces them. A small memory model answers reads one
// cycle after grant and can stall one write beat. Honours
// CACHE_DMA_CRITICAL_WORD_FIRST_EN for the expected refill beat order.
// -----------------------------------------------------------------------------
module tb_cache_dma_engine;

    typedef struct packed {
        logic [1:0]   vec;
        logic [31:0]  addr;
        logic [511:0] data;
    } fill_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, evict;
    logic [63:0]   req_addr, evict_addr;
    logic [1023:0] evict_data;
    logic [1:0]    fill_valid, evict_done;
    logic [511:0]  fill_data;
    logic [31:0]   fill_addr;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fill_cyc = 0;
    int done_cyc = 0;
    int stall_cycles = 0;

    logic [31:0]  exp_rd[$];
    wr_exp_t      exp_wr[$];
    fill_exp_t    exp_fill[$];
    logic [1:0]   exp_done[$];

    logic         rd_pend = 1'b0;
    logic [31:0]  rd_pend_addr = '0;
    logic         stall_arm = 1'b0;
    logic         stall_used = 1'b0;
    logic [31:0]  stall_addr = '0;
    int           stall_left = 0;
    logic [31:0]  hold_addr = '0, hold_data = '0;

    cache_dma_engine dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .evict_i      (evict),
        .evict_addr_i (evict_addr),
        .evict_data_i (evict_data),
        .fill_valid_o (fill_valid),
        .fill_data_o  (fill_data),
        .fill_addr_o  (fill_addr),
        .evict_done_o (evict_done),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [511:0] model_line(input logic [31:0] b);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = model(b + 32'(i * 4));
        return l;
    endfunction

    task automatic push_fill(input int c, input logic [31:0] a);
        logic [31:0] b;
        int start;
        b = a & 32'hFFFF_FFC0;
`ifdef CACHE_DMA_CRITICAL_WORD_FIRST_EN
        start = int'(a[5:2]);
`else
        start = 0;
`endif
        for (int k = 0; k < 16; k++) exp_rd.push_back(b + 32'(((start + k) % 16) * 4));
        exp_fill.push_back('{vec: 2'(1 << c), addr: b, data: model_line(b)});
    endtask

    task automatic push_evict(input int c, input logic [31:0] a, input logic [511:0] d);
        for (int k = 0; k < 16; k++) exp_wr.push_back('{addr: a + 32'(k * 4), data: d[k*32 +: 32]});
        exp_done.push_back(2'(1 << c));
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 512'(exp_wr.size()), 512'd1);
                    else begin
                        wr_exp_t e;
                        e = exp_wr.pop_front();
                        check("wr_addr", 512'(mem_addr), 512'(e.addr));
                        check("wr_data", 512'(mem_wdata), 512'(e.data));
                    end
                end else begin
                    if (exp_rd.size() == 0) check("rd_unexpected", 512'(exp_rd.size()), 512'd1);
                    else check("rd_addr", 512'(mem_addr), 512'(exp_rd.pop_front()));
                end
            end
            if (mem_req && !mem_gnt) begin
                stall_cycles++;
                check("stall_addr_stable", 512'(mem_addr), 512'(hold_addr));
                check("stall_wdata_stable", 512'(mem_wdata), 512'(hold_data));
            end
            if (fill_valid != 2'b00) begin
                fill_cyc = cyc;
                if (exp_fill.size() == 0) check("fill_unexpected", 512'(exp_fill.size()), 512'd1);
                else begin
                    fill_exp_t f;
                    f = exp_fill.pop_front();
                    check("fill_valid_vec", 512'(fill_valid), 512'(f.vec));
                    check("fill_addr", 512'(fill_addr), 512'(f.addr));
                    check("fill_data", fill_data, f.data);
                end
            end
            if (evict_done != 2'b00) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) check("done_unexpected", 512'(exp_done.size()), 512'd1);
                else check("evict_done_vec", 512'(evict_done), 512'(exp_done.pop_front()));
            end
        end
        rd_pend      = !rst && mem_req && !mem_we && mem_gnt;
        rd_pend_addr = mem_addr;
    end

    // Memory model: read data one cycle after grant; optional 3-cycle stall.
    initial begin
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = rd_pend;
            mem_rdata  = rd_pend ? model(rd_pend_addr) : 32'h0;
            if (stall_arm && !stall_used && mem_req && mem_we && mem_addr == stall_addr) begin
                stall_used = 1'b1;
                stall_left = 3;
                hold_addr  = mem_addr;
                hold_data  = mem_wdata;
            end
            if (stall_left > 0) begin
                mem_gnt = 1'b0;
                stall_left--;
            end else begin
                mem_gnt = 1'b1;
            end
        end
    end

    task automatic wait_fill(input int c);
        logic seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (fill_valid[c]) seen = 1'b1;
        end
        check("fill_seen", 512'(seen), 512'd1);
        @(posedge clk);
        #1;
        req[c] = 1'b0;
    endtask

    task automatic wait_evict(input int c);
        logic seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (evict_done[c]) seen = 1'b1;
        end
        check("evict_seen", 512'(seen), 512'd1);
        @(posedge clk);
        #1;
        evict[c] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic found;
        logic [511:0] ev_line;
        rst        = 1'b1;
        req        = '0;
        evict      = '0;
        req_addr   = '0;
        evict_addr = '0;
        evict_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req", 512'(mem_req), 512'd0);
        check("reset_fill_valid", 512'(fill_valid), 512'd0);
        check("reset_fill_data", fill_data, 512'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a refill (beat 5), then restart with req held.
        @(posedge clk);
        #1;
        req_addr[31:0] = 32'h0000_1234;
        push_fill(0, 32'h0000_1234);
        req[0] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h0000_1214) found = 1'b1;
        end
        check("beat5_reached", 512'(found), 512'd1);
        #2 rst = 1'b1;
        exp_rd.delete();
        exp_fill.delete();
        @(negedge clk);
        check("midrst_mem_req", 512'(mem_req), 512'd0);
        check("midrst_mem_addr", 512'(mem_addr), 512'd0);
        check("midrst_fill_valid", 512'(fill_valid), 512'd0);
        check("midrst_fill_data", fill_data, 512'd0);
        check("midrst_state", 512'(dut.state), 512'(cache_dma_pkg::IDLE));
        push_fill(0, 32'h0000_1234);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_fill(0);

        // Single refill with latency measurement.
        @(posedge clk);
        #1;
        req_addr[31:0] = 32'h0000_1234;
        push_fill(0, 32'h0000_1234);
        req[0] = 1'b1;
        t0 = cyc;
        wait_fill(0);
        check("fill_latency", 512'(fill_cyc - t0), 512'd33);

        // Eviction and refill on channel 1 together; beat 7 of the write stalls.
        for (int i = 0; i < 16; i++) ev_line[i*32 +: 32] = 32'hD000_0000 | 32'(i << 8) | 32'(i);
        stall_addr = 32'h0000_201C;
        stall_arm  = 1'b1;
        @(posedge clk);
        #1;
        evict_addr[63:32]  = 32'h0000_2000;
        req_addr[63:32]    = 32'h0000_3000;
        evict_data[1023:512] = ev_line;
        push_evict(1, 32'h0000_2000, ev_line);
        push_fill(1, 32'h0000_3000);
        evict[1] = 1'b1;
        req[1]   = 1'b1;
        t0 = cyc;
        wait_evict(1);
        check("evict_latency", 512'(done_cyc - t0), 512'd20);
        wait_fill(1);

        // Round-robin: both channels together, then channel 0 re-raised.
        @(posedge clk);
        #1;
        req_addr = {32'h0000_6000, 32'h0000_5000};
        push_fill(0, 32'h0000_5000);
        push_fill(1, 32'h0000_6000);
        push_fill(0, 32'h0000_7000);
        req = 2'b11;
        wait_fill(0);
        repeat (4) @(posedge clk);
        #1;
        req_addr[31:0] = 32'h0000_7000;
        req[0] = 1'b1;
        wait_fill(1);
        wait_fill(0);

        // Refill from a mid-line address (critical-word order when enabled).
        @(posedge clk);
        #1;
        req_addr[31:0] = 32'h0000_4028;
        push_fill(0, 32'h0000_4028);
        req[0] = 1'b1;
        wait_fill(0);

        repeat (4) @(posedge clk);
        check("rd_queue_empty", 512'(exp_rd.size()), 512'd0);
        check("wr_queue_empty", 512'(exp_wr.size()), 512'd0);
        check("fill_queue_empty", 512'(exp_fill.size()), 512'd0);
        check("done_queue_empty", 512'(exp_done.size()), 512'd0);
        check("stall_cycles", 512'(stall_cycles), 512'd3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_dma_engine.md
# cache_dma_engine

Parametrised DMA engine between one or more L1 caches and a word-wide memory port. It replaces the single-channel, whole-line DMA handshake of the current Cache with NUM_CH channels. Each channel has a line refill request and a line eviction (writeback) request, both serviced by round-robin arbitration. BLOCK_BITS lines are serialised into WORD_BITS beats on a grant/rvalid memory bus.

## Interface
Parameters:
- NUM_CH, 2, number of cache channels (I-cache = 0, D-cache = 1 in the default build)
- BLOCK_BITS, 512, cache line width; must be a multiple of WORD_BITS
- WORD_BITS, 32, memory beat width
- ADDR_BITS, 32, byte address width

Ports:
- clk_i  in  1  single clock; all logic rising-edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NUM_CH  refill request per channel (level, held until fill_valid_o for that channel)
- req_addr_i  in  NUM_CH*ADDR_BITS  refill byte address per channel (channel c at [c*ADDR_BITS +: ADDR_BITS])
- evict_i  in  NUM_CH  eviction request per channel (level, held until evict_done_o)
- evict_addr_i  in  NUM_CH*ADDR_BITS  eviction line address per channel
- evict_data_i  in  NUM_CH*BLOCK_BITS  eviction line data per channel
- fill_valid_o  out  NUM_CH  one-cycle pulse: fill_data_o/fill_addr_o valid for that channel
- fill_data_o  out  BLOCK_BITS  refilled line (shared by all channels)
- fill_addr_o  out  ADDR_BITS  line-aligned address of the refilled line
- evict_done_o  out  NUM_CH  one-cycle pulse: writeback complete
- mem_req_o  out  1  beat request
- mem_we_o  out  1  1 = write beat, 0 = read beat
- mem_addr_o  out  ADDR_BITS  beat byte address
- mem_wdata_o  out  WORD_BITS  write beat data
- mem_gnt_i  in  1  memory accepts the current beat
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  WORD_BITS  read data

## Operation
- BEATS = BLOCK_BITS/WORD_BITS; BEAT_BYTES = WORD_BITS/8. Line base = addr with the low log2(BLOCK_BITS/8) bits cleared.
- States: IDLE, WR_BEAT, RD_REQ, RD_WAIT, DONE.
- IDLE: scan channels starting at rr_ptr. The first channel with evict_i or req_i is chosen. For that channel evict has priority over req, so a dirty line is written before its refill. The engine latches the channel, the kind, the line base and, for an evict, the full line. A write goes to WR_BEAT; a read goes to RD_REQ.
- WR_BEAT: mem_req_o=1, mem_we_o=1, mem_addr_o = base + beat*BEAT_BYTES, mem_wdata_o = latched line word[beat]. On mem_gnt_i, beat increments. If the beat was the last, the state goes to DONE.
- RD_REQ: mem_req_o=1, mem_we_o=0, beat address as above. On mem_gnt_i the state goes to RD_WAIT.
- RD_WAIT: mem_req_o=0. On mem_rvalid_i, mem_rdata_i is stored into fill_data_o word[beat] and beat increments. The state then returns to RD_REQ, or goes to DONE after the last beat.
- DONE: pulse evict_done_o[ch] or fill_valid_o[ch] for one cycle. Set rr_ptr = (ch+1) mod NUM_CH, then return to IDLE.
- Beat counter width is clog2(BEATS). The address adds with ADDR_BITS wrap.
- Addresses and data on mem_* stay stable while mem_req_o=1 and mem_gnt_i=0.
- Inputs for a channel are sampled only in IDLE. A request dropped mid-service is still completed and its done pulse still issued.
- fill_data_o holds its value until the next refill overwrites it.

## Timing
- Reset values: all outputs 0, fill_data_o 0, rr_ptr 0, state IDLE. A reset mid-transfer aborts immediately with no done pulse.
- A request seen in IDLE in cycle N gives mem_req_o=1 in cycle N+1.
- Write line: BEATS grant cycles, plus 1 DONE cycle, plus 1 IDLE cycle.
- Read line: each beat takes at least 2 cycles (grant, then rvalid no earlier than the cycle after grant).
- With mem_gnt_i tied high and rvalid one cycle after grant, a 16-beat refill completes with fill_valid_o at N+33.
- Same cycle: evict_i and req_i on one channel → two transactions, evict first, refill when that channel next wins arbitration. Requests on all channels → served strictly round-robin.
- mem_rvalid_i outside RD_WAIT is ignored.

## Configuration
- CACHE_DMA_CRITICAL_WORD_FIRST_EN defined:
  - Refill read beats start at the beat containing req_addr_i and wrap modulo BEATS to the line base.
  - Each word is stored at its true line position.
  - fill_addr_o stays line-aligned.
- Undefined: refill beats always start at beat 0.
- Evictions always start at beat 0.

## Structure
- cache_dma_pkg: state enum (IDLE, WR_BEAT, RD_REQ, RD_WAIT, DONE) and a kind enum (KIND_EVICT, KIND_FILL).
- One sub-module, cache_dma_rr_arb: NUM_CH-wide round-robin priority picker. Inputs: request vector and rr_ptr. Outputs: one-hot grant plus a valid flag.

## Test plan
- Reset:
  - Stimulus: assert rst_i mid-refill at beat 5.
  - Response: all outputs 0 next cycle, no fill_valid_o, state IDLE.
  - Stimulus: deassert rst_i with req_i held.
  - Response: refill restarts at beat 0.
- Single refill, channel 0, address 0x0000_1234, gnt tied 1, rvalid 1 cycle after grant:
  - Required: 16 reads at 0x1200, 0x1204 … 0x123C, in that order.
  - Required: fill_addr_o=0x1200, and fill_data_o matches memory model words.
  - Required: fill_valid_o=2'b01 at cycle N+33.
- Eviction then refill, channel 1, evict_addr 0x2000, req_addr 0x3000, both raised together:
  - Required: 16 writes to 0x2000–0x203C with data words 0..15 of evict_data, then evict_done_o[1].
  - Required: reads from 0x3000 follow, then fill_valid_o[1].
- Round-robin, req_i=2'b11 raised in the same cycle:
  - Required: channel 0 served first, then channel 1.
  - Required: re-raising channel 0 during channel 1's service puts channel 0 after channel 1.
- Backpressure, mem_gnt_i low for 3 cycles on beat 7 of a write:
  - Required: mem_addr_o and mem_wdata_o stable across all 3 cycles.
  - Required: no beat skipped or duplicated.
- CACHE_DMA_CRITICAL_WORD_FIRST_EN defined, req_addr 0x0000_4028:
  - Required: first read at 0x4028, then through 0x403C, wrap to 0x4000, last read at 0x4024.
  - Required: fill_data_o equals the linear line contents.
